// File: rtl/control_unit.sv
// Multi-cycle Moore control unit: fetch T0-T2, opcode-dependent execute T3-T7, IDLE/HALT.
// Define CONTROL_UNIT_MUL_DIV_EN to enable the mul/div execute sequence; otherwise those opcodes are illegal.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] ir,
  output logic        pc_out,
  output logic        zlo_out,
  output logic        zhi_out,
  output logic        mdr_out,
  output logic        r_out,
  output logic        ba_out,
  output logic        c_sign_extended_out,
  output logic        mar_enable,
  output logic        mdr_enable,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        z_enable,
  output logic        pc_enable,
  output logic        lo_enable,
  output logic        hi_enable,
  output logic        r_in,
  output logic        pc_increment,
  output logic        read,
  output logic        ram_write,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic [4:0]  alu_op,
  output logic        running,
  output logic        illegal
);

`ifdef CONTROL_UNIT_MUL_DIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  localparam logic [4:0] OP_ADD = 5'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_LD, C_LDI, C_ST, C_RTYPE, C_IMM, C_UNARY, C_MULDIV, C_ILLEGAL
  } class_t;

  state_t     r_state;
  state_t     w_state_next;
  state_t     w_last;
  class_t     w_cls;
  logic [4:0] r_opcode;
  logic       w_unused_ir;

  // Only the opcode field is consumed here; register fields are decoded by the datapath.
  assign w_unused_ir = ^ir[26:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= S_IDLE;
      r_opcode <= 5'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_T2)
        r_opcode <= ir[31:27];
    end
  end

  always_comb begin
    w_cls = C_ILLEGAL;
    if (r_opcode == 5'd0)
      w_cls = C_LD;
    else if (r_opcode == 5'd1)
      w_cls = C_LDI;
    else if (r_opcode == 5'd2)
      w_cls = C_ST;
    else if (r_opcode >= 5'd3 && r_opcode <= 5'd11)
      w_cls = C_RTYPE;
    else if (r_opcode >= 5'd12 && r_opcode <= 5'd14)
      w_cls = C_IMM;
    else if (r_opcode == 5'd17 || r_opcode == 5'd18)
      w_cls = C_UNARY;
    else if (MULDIV_EN && (r_opcode == 5'd15 || r_opcode == 5'd16))
      w_cls = C_MULDIV;
  end

  always_comb begin
    case (w_cls)
      C_LD, C_ST:             w_last = S_T7;
      C_LDI, C_RTYPE, C_IMM:  w_last = S_T5;
      C_UNARY:                w_last = S_T4;
      C_MULDIV:               w_last = S_T6;
      default:                w_last = S_T3;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: w_state_next = start ? S_T0 : S_IDLE;
      S_T0:   w_state_next = S_T1;
      S_T1:   w_state_next = S_T2;
      S_T2:   w_state_next = S_T3;
      S_HALT: w_state_next = S_HALT;
      default: begin
        if (w_cls == C_ILLEGAL)
          w_state_next = S_HALT;
        else if (r_state == w_last)
          w_state_next = start ? S_T0 : S_IDLE;
        else
          w_state_next = state_t'(r_state + 4'd1);
      end
    endcase
  end

  always_comb begin
    {pc_out, zlo_out, zhi_out, mdr_out, r_out, ba_out, c_sign_extended_out} = '0;
    {mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable} = '0;
    {lo_enable, hi_enable, r_in, pc_increment, read, ram_write} = '0;
    {gra, grb, grc, illegal} = '0;
    running = (r_state != S_IDLE) && (r_state != S_HALT);
    alu_op  = running ? OP_ADD : 5'd0;
    // Arithmetic classes pass their own opcode to the ALU for the whole execute phase.
    if (r_state >= S_T3 && r_state <= S_T7 &&
        (w_cls == C_RTYPE || w_cls == C_IMM || w_cls == C_UNARY || w_cls == C_MULDIV))
      alu_op = r_opcode;
    case (r_state)
      S_T0: {pc_out, mar_enable, pc_increment, z_enable} = '1;
      S_T1: {zlo_out, pc_enable, read, mdr_enable} = '1;
      S_T2: {mdr_out, ir_enable} = '1;
      S_T3: begin
        case (w_cls)
          C_LD, C_LDI, C_ST:  {grb, ba_out, y_enable} = '1;
          C_RTYPE, C_IMM:     {grb, r_out, y_enable} = '1;
          C_UNARY:            {grb, r_out, z_enable} = '1;
          C_MULDIV:           {gra, r_out, y_enable} = '1;
          default:            illegal = 1'b1;
        endcase
      end
      S_T4: begin
        case (w_cls)
          C_LD, C_LDI, C_ST, C_IMM: {c_sign_extended_out, z_enable} = '1;
          C_RTYPE:                  {grc, r_out, z_enable} = '1;
          C_UNARY:                  {zlo_out, gra, r_in} = '1;
          C_MULDIV:                 {grb, r_out, z_enable} = '1;
          default:                  ;
        endcase
      end
      S_T5: begin
        case (w_cls)
          C_LD, C_ST:              {zlo_out, mar_enable} = '1;
          C_LDI, C_RTYPE, C_IMM:   {zlo_out, gra, r_in} = '1;
          C_MULDIV:                {zlo_out, lo_enable} = '1;
          default:                 ;
        endcase
      end
      S_T6: begin
        case (w_cls)
          C_LD:     {read, mdr_enable} = '1;
          C_ST:     {gra, r_out, mdr_enable} = '1;
          C_MULDIV: {zhi_out, hi_enable} = '1;
          default:  ;
        endcase
      end
      S_T7: begin
        case (w_cls)
          C_LD:    {mdr_out, gra, r_in} = '1;
          C_ST:    ram_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
